gf2_poly_divider: RTL and testbench

- Sequential binary-polynomial long divider over GF(2); the inverse of the team's carry-less Karatsuba multipliers.
- Takes a (2N-1)-bit product-width dividend and an N-bit divisor, and returns quotient and remainder.
- Processes one dividend bit per cycle, with valid/ready handshakes on input and output.
- Used to check multiplier outputs and to recover factors/remainders downstream of the OKA multiplier tree.

---
 rtl/gf2_poly_divider_if.sv | 26 ++
 rtl/gf2_poly_divider.sv | 128 ++++++++++++
 tb/tb_gf2_poly_divider.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gf2_poly_divider_if.sv
// Job/result handshake bundle for the GF(2) polynomial divider.
// The master side issues dividend/divisor jobs and consumes results;
// the slave side is the divider itself.
interface gf2_poly_divider_if #(
    parameter int N = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [2*N-2:0]     dividend;
    logic [N-1:0]       divisor;
    logic               out_valid;
    logic               out_ready;
    logic [2*N-2:0]     quotient;
    logic [N-2:0]       remainder;
    logic               div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/gf2_poly_divider.sv
// Sequential GF(2) polynomial long divider: (2N-1)-bit dividend by N-bit
// divisor, one dividend bit per cycle, MSB first. Quotient and remainder
// are registered and held until the next job overwrites them.
module gf2_poly_divider #(
    parameter int N = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    gf2_poly_divider_if.slave  bus
);
    localparam int W  = 2 * N - 1;
    localparam int DW = $clog2(N);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

    state_t          state;
    logic [W-1:0]    d;
    logic [N-1:0]    v;
    logic [W-1:0]    q;
    logic [N-1:0]    r;
    logic [DW-1:0]   deg_v;
    logic [CW-1:0]   cnt;

    logic            in_ready_r;
    logic            out_valid_r;
    logic [W-1:0]    quotient_r;
    logic [N-2:0]    remainder_r;
    logic            div_by_zero_r;

    logic [N-1:0]    t;
    logic            q_bit;
    logic [N-1:0]    r_next;

    // Index of the highest set bit of a nonzero divisor (degree of the polynomial).
    function automatic logic [DW-1:0] msb_index(input logic [N-1:0] val);
        logic [DW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (val[i]) idx = DW'(i);
        end
        return idx;
    endfunction

    // One long-division step: shift in the next dividend bit, subtract
    // (XOR) the divisor whenever the partial remainder reaches degV.
    always_comb begin
        t      = {r[N-2:0], d[cnt]};
        q_bit  = t[deg_v];
        r_next = q_bit ? (t ^ v) : t;
    end

    // Control FSM with all datapath state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            d             <= '0;
            v             <= '0;
            q             <= '0;
            r             <= '0;
            deg_v         <= '0;
            cnt           <= '0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        d          <= bus.dividend;
                        v          <= bus.divisor;
                        q          <= '0;
                        r          <= '0;
                        in_ready_r <= 1'b0;
                        state      <= NORM;
                    end
                end
                NORM: begin
                    if (v == '0) begin
                        quotient_r    <= '0;
                        remainder_r   <= '0;
                        div_by_zero_r <= 1'b1;
                        out_valid_r   <= 1'b1;
                        state         <= DONE;
                    end else begin
                        deg_v         <= msb_index(v);
                        cnt           <= CW'(W - 1);
                        div_by_zero_r <= 1'b0;
                        state         <= DIV;
                    end
                end
                DIV: begin
                    q[cnt] <= q_bit;
                    r      <= r_next;
                    if (cnt == '0) begin
                        // Final step: the last quotient bit goes straight to the output.
                        quotient_r  <= {q[W-1:1], q_bit};
                        remainder_r <= r_next[N-2:0];
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;
endmodule

// File: tb/tb_gf2_poly_divider.sv
// Bench for gf2_poly_divider: directed table, handshake and reset sequences,
// and randomized jobs checked against a textbook polynomial long-division model.
module tb_gf2_poly_divider;
    localparam int N = 5;
    localparam int W = 2 * N - 1;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    gf2_poly_divider_if #(.N(N)) bus ();

    gf2_poly_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   dividend;
        logic [N-1:0]   divisor;
        logic [W-1:0]   exp_q;
        logic [N-2:0]   exp_r;
        logic           exp_dz;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Carry-less product of two N-bit polynomials.
    function automatic logic [W-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++)
            if (a[i]) p = p ^ (W'(b) << i);
        return p;
    endfunction

    // Schoolbook polynomial division: cancel the leading term repeatedly.
    function automatic void ref_div(input logic [W-1:0] a, input logic [N-1:0] b,
                                    output logic [W-1:0] q, output logic [N-2:0] r,
                                    output logic dz);
        logic [W-1:0] rem;
        int db;
        q = '0; r = '0; dz = 1'b0;
        if (b == '0) begin
            dz = 1'b1;
            return;
        end
        db = 0;
        for (int i = 0; i < N; i++) if (b[i]) db = i;
        rem = a;
        for (int i = W - 1; i >= db; i--) begin
            if (rem[i]) begin
                q[i - db] = 1'b1;
                rem = rem ^ (W'(b) << (i - db));
            end
        end
        r = rem[N-2:0];
    endfunction

    task automatic do_job(input logic [W-1:0] a, input logic [N-1:0] b, input int hold,
                          output logic [W-1:0] q, output logic [N-2:0] r,
                          output logic dz, output int lat);
        int guard;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q  = bus.quotient;
        r  = bus.remainder;
        dz = bus.div_by_zero;
        repeat (hold) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] q, eq, sq;
        logic [N-2:0] r, er, sr;
        logic         dz, edz;
        logic [N-1:0] a, b;
        logic [W-1:0] p;
        int           lat, guard, unstable;

        n_cmp = 0;
        n_fail = 0;

        tbl[0] = '{9'b001111001, 5'b00111, 9'b000010011, 4'b0000, 1'b0};
        tbl[1] = '{9'b000000111, 5'b00010, 9'b000000011, 4'b0001, 1'b0};
        tbl[2] = '{9'b101010101, 5'b00001, 9'b101010101, 4'b0000, 1'b0};
        tbl[3] = '{9'b111111111, 5'b10000, 9'b000011111, 4'b1111, 1'b0};
        tbl[4] = '{9'h1AB,       5'b00000, 9'b000000000, 4'b0000, 1'b1};
        tbl[5] = '{9'b001111001, 5'b00111, 9'b000010011, 4'b0000, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_div_by_zero", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            do_job(tbl[i].dividend, tbl[i].divisor, 0, q, r, dz, lat);
            check($sformatf("tbl%0d_quotient", i), q, tbl[i].exp_q);
            check($sformatf("tbl%0d_remainder", i), r, tbl[i].exp_r);
            check($sformatf("tbl%0d_div_by_zero", i), dz, tbl[i].exp_dz);
            check($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_dz ? 2 : 2 * N + 1);
        end

        // Handshake: busy in_valid ignored, result held while out_ready low
        @(negedge clk);
        bus.dividend = 9'b001111001;
        bus.divisor  = 5'b00111;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy_in_ready", bus.in_ready, 0);
        bus.dividend = 9'b111111111;
        bus.divisor  = 5'b00001;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 64) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("hs_out_valid", bus.out_valid, 1);
        check("hs_quotient", bus.quotient, 9'b000010011);
        check("hs_remainder", bus.remainder, 4'b0000);
        sq = bus.quotient;
        sr = bus.remainder;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.quotient !== sq || bus.remainder !== sr || bus.out_valid !== 1'b1
                || bus.in_ready !== 1'b0)
                unstable++;
        end
        check("hs_hold_unstable_cycles", unstable, 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("hs_after_in_ready", bus.in_ready, 1);
        check("hs_after_out_valid", bus.out_valid, 0);
        check("hs_after_quotient_kept", bus.quotient, 9'b000010011);

        // Reset in the middle of DIV
        @(negedge clk);
        bus.dividend = 9'b101010101;
        bus.divisor  = 5'b00011;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_quotient", bus.quotient, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_out_valid", bus.out_valid, 0);
        check("postrst_in_ready", bus.in_ready, 1);
        do_job(9'b000000111, 5'b00010, 0, q, r, dz, lat);
        check("postrst_quotient", q, 9'b000000011);
        check("postrst_remainder", r, 4'b0001);
        check("postrst_latency", lat, 2 * N + 1);

        // Random round trips: (a*b) / b == a, remainder 0
        for (int i = 0; i < 40; i++) begin
            a = N'($urandom_range(0, (1 << N) - 1));
            b = N'($urandom_range(1, (1 << N) - 1));
            p = clmul(a, b);
            do_job(p, b, $urandom_range(0, 2), q, r, dz, lat);
            check($sformatf("rt%0d_quotient", i), q, W'(a));
            check($sformatf("rt%0d_remainder", i), r, 0);
            check($sformatf("rt%0d_div_by_zero", i), dz, 0);
        end

        // Random arbitrary dividend/divisor vs reference model
        for (int i = 0; i < 40; i++) begin
            p = W'($urandom);
            b = (i % 8 == 0) ? '0 : N'($urandom);
            ref_div(p, b, eq, er, edz);
            do_job(p, b, 0, q, r, dz, lat);
            check($sformatf("rnd%0d_quotient", i), q, eq);
            check($sformatf("rnd%0d_remainder", i), r, er);
            check($sformatf("rnd%0d_div_by_zero", i), dz, edz);
            check($sformatf("rnd%0d_latency", i), lat, edz ? 2 : 2 * N + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
